// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte-stream program loader that writes 32-bit words into a CPU instruction port
// Stream: 16-bit word count (MSB first), then N words of 4 bytes (MSB first); CPU held in reset until loaded.
module instruction_loader #(
  parameter int MAX_WORDS     = 256,
  parameter int RELEASE_DELAY = 4   // must be >= 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  input  logic [7:0]  IN_DATA,
  output logic        IN_READY,
  output logic [31:0] W_Ins,
  output logic        WE,
  output logic        CPU_RST,
  output logic        DONE,
  output logic        ERR
);
  localparam int RW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_RELEASE, S_DONE, S_ERROR
  } state_t;

  state_t        r_state, w_next;
  logic [15:0]   r_len;
  logic [15:0]   r_word_cnt;
  logic [1:0]    r_byte_cnt;
  logic [23:0]   r_shift;
  logic [RW-1:0] r_rel_cnt;
  logic [31:0]   r_w_ins;
  logic          r_in_ready, r_we, r_cpu_rst, r_done, r_err;
  logic          w_hs;
  logic [15:0]   w_len_full;

  // r_in_ready always mirrors the current state; it is only 0 in a ready state while RST is held
  assign w_hs       = IN_VALID & r_in_ready;
  assign w_len_full = {r_len[15:8], IN_DATA};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_LEN_HI;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN_HI: if (w_hs) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_hs) begin
          if (w_len_full == 16'd0)                           w_next = S_RELEASE;
          else if ({1'b0, w_len_full} > 17'(MAX_WORDS))      w_next = S_ERROR;
          else                                               w_next = S_DATA;
        end
      end
      S_DATA:    if (w_hs && r_byte_cnt == 2'd3) w_next = S_WRITE;
      S_WRITE:   w_next = ((r_word_cnt + 16'd1) == r_len) ? S_RELEASE : S_DATA;
      S_RELEASE: if (r_rel_cnt == RW'(RELEASE_DELAY - 1)) w_next = S_DONE;
      S_DONE:    w_next = S_DONE;
      S_ERROR:   w_next = S_ERROR;
      default:   w_next = S_LEN_HI;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with the state it belongs to
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_len      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_rel_cnt  <= '0;
      r_w_ins    <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_in_ready <= (w_next == S_LEN_HI) || (w_next == S_LEN_LO) || (w_next == S_DATA);
      r_we       <= (w_next == S_WRITE);
      r_cpu_rst  <= (w_next != S_DONE);
      r_done     <= (w_next == S_DONE);
      r_err      <= (w_next == S_ERROR);
      case (r_state)
        S_LEN_HI: if (w_hs) r_len[15:8] <= IN_DATA;
        S_LEN_LO: if (w_hs) r_len[7:0]  <= IN_DATA;
        S_DATA: begin
          if (w_hs) begin
            r_shift    <= {r_shift[15:0], IN_DATA};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) r_w_ins <= {r_shift, IN_DATA};
          end
        end
        S_WRITE: begin
          r_word_cnt <= r_word_cnt + 16'd1;
          r_byte_cnt <= 2'd0;
        end
        S_RELEASE: r_rel_cnt <= r_rel_cnt + RW'(1);
        default: ;
      endcase
    end
  end

  assign IN_READY = r_in_ready;
  assign W_Ins    = r_w_ins;
  assign WE       = r_we;
  assign CPU_RST  = r_cpu_rst;
  assign DONE     = r_done;
  assign ERR      = r_err;
endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - randomized self-checking bench for instruction_loader
// Expected words, accepted-byte counts and strobe/release timing come from parsing each stream directly.
module tb_instruction_loader;
  localparam int MAXW = 256;
  localparam int RD   = 4;
  localparam int STALL = 8;

  typedef logic [7:0] bq_t[$];

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [7:0]  IN_DATA = 8'h00;
  logic        IN_READY;
  logic [31:0] W_Ins;
  logic        WE;
  logic        CPU_RST;
  logic        DONE;
  logic        ERR;

  instruction_loader #(.MAX_WORDS(MAXW), .RELEASE_DELAY(RD)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .IN_READY(IN_READY), .W_Ins(W_Ins), .WE(WE), .CPU_RST(CPU_RST),
    .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: records every strobe and protocol violations; cleared while RST is held
  logic [31:0] we_words[$];
  int          we_cycs[$];
  int          hs_cyc[$];
  int          gaps[$];
  int          rel_cyc = -1;
  int          consec = 0, hold_bad = 0, ready_bad = 0;
  logic        prev_we = 1'b0;
  logic [31:0] last_wins = '0;

  always @(negedge CLK) begin
    if (RST) begin
      we_words.delete(); we_cycs.delete();
      rel_cyc = -1; consec = 0; hold_bad = 0; ready_bad = 0;
      prev_we = 1'b0; last_wins = '0;
    end else begin
      if (WE) begin
        we_words.push_back(W_Ins);
        we_cycs.push_back(cyc);
        if (prev_we) consec++;
        last_wins = W_Ins;
      end else if (W_Ins !== last_wins) begin
        hold_bad++;
      end
      prev_we = WE;
      if (!CPU_RST && rel_cyc < 0) rel_cyc = cyc;
      if ((DONE || ERR) && IN_READY) ready_bad++;
    end
  end

  task automatic reset_dut();
    @(negedge CLK);
    IN_VALID = 1'b0;
    RST = 1'b1;
    #1;
    check("rst_async_ctl", {27'd0, WE, IN_READY, CPU_RST, DONE, ERR}, 32'h0000_0004);
    check("rst_async_wins", W_Ins, 32'h0);
    repeat (2) @(negedge CLK);
    check("rst_held_ctl", {27'd0, WE, IN_READY, CPU_RST, DONE, ERR}, 32'h0000_0004);
    RST = 1'b0;
    @(negedge CLK);
    check("rdy_after_rst", {31'd0, IN_READY}, 32'd1);
  endtask

  // Drives bytes from a negedge; gives up on a byte after STALL refused cycles
  task automatic send_stream(input bq_t s, output int acc);
    int g, tries;
    bit taken;
    acc = 0;
    for (int i = 0; i < s.size(); i++) begin
      g = (i < gaps.size()) ? gaps[i] : 0;
      repeat (g) begin
        IN_VALID = 1'b0;
        IN_DATA = 8'($urandom);
        @(negedge CLK);
      end
      IN_VALID = 1'b1;
      IN_DATA = s[i];
      taken = 1'b0;
      tries = 0;
      while (!taken && tries < STALL) begin
        if (IN_READY) begin
          hs_cyc.push_back(cyc);
          taken = 1'b1;
          acc++;
        end
        @(negedge CLK);
        tries++;
      end
      if (!taken) break;
    end
    IN_VALID = 1'b0;
    IN_DATA = 8'($urandom);
  endtask

  task automatic run_load(input string tag, input bq_t s);
    int n, exp_nw, exp_acc, acc, nchk, exp_rel, last;
    bit exp_err;
    logic [31:0] w;
    n = {s[0], s[1]};
    exp_err = (n > MAXW);
    exp_nw  = exp_err ? 0 : n;
    exp_acc = exp_err ? 2 : 2 + 4 * n;
    hs_cyc.delete();
    send_stream(s, acc);
    for (int t = 0; t < 3000 && !(DONE || ERR); t++) @(negedge CLK);
    repeat (RD + 4) @(negedge CLK);
    check({tag, "_accepted"}, acc, exp_acc);
    check({tag, "_we_count"}, we_words.size(), exp_nw);
    nchk = (we_words.size() < exp_nw) ? we_words.size() : exp_nw;
    for (int k = 0; k < nchk; k++) begin
      w = {s[2 + 4*k], s[3 + 4*k], s[4 + 4*k], s[5 + 4*k]};
      check($sformatf("%s_word%0d", tag, k), we_words[k], w);
      check($sformatf("%s_we_cyc%0d", tag, k), we_cycs[k], hs_cyc[2 + 4*k + 3] + 1);
    end
    check({tag, "_status"}, {29'd0, CPU_RST, DONE, ERR}, exp_err ? 32'd5 : 32'd2);
    if (exp_err) begin
      exp_rel = -1;
    end else if (n == 0) begin
      exp_rel = hs_cyc[1] + 1 + RD;
    end else begin
      last = 2 + 4 * n - 1;
      exp_rel = hs_cyc[last] + 2 + RD;
    end
    check({tag, "_release_cyc"}, rel_cyc, exp_rel);
    check({tag, "_proto"}, consec + hold_bad + ready_bad, 0);
    gaps.delete();
  endtask

  task automatic make_stream(input int n, output bq_t s);
    s.delete();
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    if (n <= MAXW)
      for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
  endtask

  initial begin
    bq_t s;
    int acc, n;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s;
    int acc, n;
    reset_dut();

    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    run_load("two_words", s);
    if (we_cycs.size() >= 2) check("two_words_spacing", we_cycs[1] - we_cycs[0], 5);
    check("two_words_last_wins", W_Ins, 32'hAC080000);

    reset_dut();
    s = '{8'h00, 8'h00};
    run_load("zero_len", s);

    reset_dut();
    s = '{8'h01, 8'h01};
    run_load("too_long", s);
    repeat (20) @(negedge CLK);
    check("too_long_hold", {29'd0, IN_READY, CPU_RST, ERR}, 32'd3);

    reset_dut();
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    gaps = '{0, 0, 0, 0, 3, 0};
    run_load("gap_word", s);

    reset_dut();
    s = '{8'h00, 8'h03, 8'hDE, 8'hAD};
    hs_cyc.delete();
    send_stream(s, acc);
    check("abort_partial_acc", acc, 4);
    reset_dut();
    check("abort_no_we", we_words.size(), 0);
    s = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    run_load("after_abort", s);

    reset_dut();
    s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    run_load("extra_bytes", s);
    check("extra_bytes_wins", W_Ins, 32'h11223344);

    reset_dut();
    make_stream(MAXW, s);
    run_load("max_len", s);

    reset_dut();
    make_stream($urandom_range(MAXW + 1, 65535), s);
    run_load("rand_err", s);

    for (int it = 0; it < 10; it++) begin
      reset_dut();
      n = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
      make_stream(n, s);
      for (int i = 0; i < s.size(); i++) gaps.push_back($urandom_range(0, 3));
      run_load($sformatf("rand%0d", it), s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256: largest accepted program length in words.
REQ-002 Parameter RELEASE_DELAY, default 4: cycles between the last word write and CPU_RST deassertion.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high, with ports named CLK and RST.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 IN_VALID  input  1  byte-stream valid.
REQ-007 IN_DATA  input  8  byte-stream data.
REQ-008 IN_READY  output  1  byte accepted when IN_VALID and IN_READY are both high at a rising CLK edge.
REQ-009 W_Ins  output  32  instruction word driven to the CPU instruction write port.
REQ-010 WE  output  1  one-cycle instruction write strobe; W_Ins is valid while WE is high.
REQ-011 CPU_RST  output  1  reset to the CPU, held high while loading.
REQ-012 DONE  output  1  program loaded and CPU released.
REQ-013 ERR  output  1  length error, sticky until RST.

Function
REQ-014 Stream format: 16-bit word count N, high byte first, then N words of 4 bytes each, each word most-significant byte first.
REQ-015 States SHALL be LEN_HI, LEN_LO, DATA, WRITE, RELEASE, DONE, ERROR; the state after reset is LEN_HI.
REQ-016 LEN_HI: on a handshake, latch N[15:8] and go to LEN_LO.
REQ-017 LEN_LO: on a handshake, latch N[7:0].
- N==0: go to RELEASE.
- N>MAX_WORDS: go to ERROR.
- Otherwise: go to DATA.
REQ-018 DATA: on each handshake, shift the byte into the word assembler.
- Increment the 2-bit byte counter.
- On the 4th byte, go to WRITE.
REQ-019 WRITE, exactly one cycle:
- WE=1, W_Ins = assembled word, word counter increments.
- Go to RELEASE if word counter+1 == N, else to DATA with byte counter 0.
REQ-020 IN_READY SHALL be 1 only in LEN_HI, LEN_LO and DATA; it is 0 in WRITE, so there is one bubble cycle per word.
REQ-021 Peak throughput: 1 word per 5 cycles; word k (0-based) produces a WE pulse the cycle after its 4th byte handshake.
REQ-022 RELEASE: count RELEASE_DELAY cycles with CPU_RST still 1, then go to DONE.
REQ-023 DONE: CPU_RST=0, DONE=1, IN_READY=0; the block stays in DONE until RST, and extra input bytes are ignored.
REQ-024 ERROR: ERR=1, CPU_RST=1, IN_READY=0, WE=0; the block stays in ERROR until RST.
REQ-025 An IN_VALID gap of any length mid-word or mid-length SHALL stall without losing assembled bytes.
REQ-026 WE SHALL never be high in two consecutive cycles.
REQ-027 WE SHALL never be high outside WRITE.
REQ-028 Exactly N WE pulses SHALL be issued per load.
REQ-029 W_Ins SHALL hold its last value when WE=0.
REQ-030 Counters: the word counter is 16 bits and is compared against N, so N==MAX_WORDS is accepted and has no wrap.
REQ-031 Outputs SHALL be registered, with no combinational path from IN_VALID/IN_DATA to any output except IN_READY (IN_READY depends on state only).

Reset
REQ-032 While RST=1 and on its assertion:
- W_Ins=0, WE=0, IN_READY=0, CPU_RST=1, DONE=0, ERR=0.
- All counters 0, state LEN_HI.
REQ-033 IN_READY SHALL rise in the first cycle after RST deasserts.
REQ-034 RST asserted mid-load SHALL abort immediately, with no further WE; the next load restarts at LEN_HI.

Verification
REQ-035 Stream 00 02 20 08 00 05 AC 08 00 00 at full rate:
- WE pulses with W_Ins=32'h20080005, then 32'hAC080000, exactly 5 cycles apart.
- CPU_RST falls 4 cycles after the second WE; DONE=1.
REQ-036 Stream 00 00: no WE; CPU_RST falls RELEASE_DELAY cycles after the second byte; DONE=1.
REQ-037 Stream 01 01 (N=257, MAX_WORDS=256): ERR=1, IN_READY=0, no WE, CPU_RST stays 1 indefinitely.
REQ-038 Stream 00 01 12 34 56 78 with 3 idle IN_VALID cycles between bytes 34 and 56: single WE with W_Ins=32'h12345678.
REQ-039 RST pulse after 2 data bytes of a 3-word load, then a valid 1-word stream: exactly one WE, with the new word; DONE=1.
REQ-040 Bytes presented after DONE: IN_READY=0, no WE, outputs unchanged.
